muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own HI/LO registers for the 5-stage pipeline.
- Accepts an operation from the EX stage and runs a shift-add multiply or a restoring divide over WIDTH cycles.
- Drives a stall request to the hazard unit while busy.
- Serves HI/LO reads (mfhi/mflo) and direct writes (mthi/mtlo) from WB.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- startE  in  1  EX-stage mult/div request; sampled only in IDLE.
- opE  in  1  0 = multiply, 1 = divide.
- signedE  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu).
- srcaE  in  WIDTH  multiplicand / dividend.
- srcbE  in  WIDTH  multiplier / divisor.
- mfhlD  in  2  ID-stage read request: 01 = mflo, 10 = mfhi, 00 = none.
- muldivD  in  1  ID-stage instruction is mult/div.
- hlwriteW  in  1  WB-stage mthi/mtlo write enable.
- hlselW  in  1  1 = HI, 0 = LO.
- wdataW  in  WIDTH  write data.
- mfhlW  in  2  WB read select, same encoding as mfhlD.
- hlrdataW  out  WIDTH  combinational HI or LO per mfhlW; 0 when 00.
- busy  out  1  RUN or FIX.
- stallD  out  1  busy & (mfhlD != 00 | muldivD).
- done  out  1  one-cycle pulse when HI/LO are updated from a result.

Behaviour:
- Reset (sync): state = IDLE; HI = LO = 0; counter = 0; busy = stallD = done = 0; internal accumulators = 0.
- States: IDLE, RUN, FIX.
- IDLE -> RUN on startE at edge T.
  - Capture |srcaE|, |srcbE| (absolute values when signedE, raw otherwise).
  - Capture result sign:
    - multiply: sign(a) ^ sign(b).
    - divide: quotient sign = sign(a) ^ sign(b); remainder sign = sign(a).
  - Load counter = WIDTH.
- RUN: one radix-2 step per cycle.
  - Multiply: {P_hi, P_lo} shift-add, 2*WIDTH-bit product.
  - Divide: restoring step, remainder WIDTH+1 bits, quotient shifts in.
  - Counter decrements each cycle; RUN -> FIX when the counter reaches 1 at an edge, i.e. after exactly WIDTH steps.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Write HI/LO at the edge leaving FIX.
    - Multiply: HI = upper half, LO = lower half.
    - Divide: LO = quotient, HI = remainder.
  - Assert done during FIX; FIX -> IDLE.
- Latency: start edge T -> HI/LO valid after edge T+WIDTH+1. busy is high from cycle T+1 through T+WIDTH+1.
- Divide by zero: no trap, still full latency. LO = all ones; HI = dividend (original signed value).
- Signed overflow (-2^(WIDTH-1) / -1): LO = -2^(WIDTH-1), HI = 0.
- startE while busy is ignored; stallD guarantees it cannot occur legally.
- hlwriteW:
  - Applies in IDLE and in RUN; the later FIX result overwrites it.
  - If it coincides with the FIX write edge, the FIX result wins.
  - startE and hlwriteW in the same IDLE cycle: both take effect.
- hlrdataW reflects HI/LO as registered, including a same-cycle hlwriteW not yet committed; there is no bypass.
- Reset mid-operation aborts to IDLE; HI/LO are cleared.

Decomposition:
- Shared package muldiv_pkg holds:
  - state enum {IDLE, RUN, FIX};
  - OP_MUL/OP_DIV constants;
  - MFHL_NONE/LO/HI 2-bit encodings, shared with the main decoder.
- Sub-module muldiv_step: combinational single-iteration datapath (add-shift or subtract-restore) selected by op.
- The sequencer holds state, counter, sign flags and HI/LO.

Test Plan:
- Unsigned mult 0xFFFFFFFF x 2 -> after 33 cycles HI = 0x00000001, LO = 0xFFFFFFFE; done pulses once; busy high 33 cycles.
- Signed div -7 / 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); signed mult -3 x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- divu 100 / 0 -> LO = 0xFFFFFFFF, HI = 100; signed 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- During busy, mfhlD = 10 or muldivD = 1 -> stallD = 1; startE pulsed mid-RUN -> ignored, result unchanged.
- hlwriteW HI = 0x1234 in IDLE -> mfhlW = 10 returns 0x1234; hlwriteW during RUN -> overwritten by final result.
- Reset at RUN step 10 -> next cycle IDLE, busy = 0, HI = LO = 0, no done pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg : shared states and encodings for the mult/div unit       |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [1:0] MFHL_NONE = 2'b00;
  localparam logic [1:0] MFHL_LO   = 2'b01;
  localparam logic [1:0] MFHL_HI   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step : one radix-2 iteration, shift-add or restoring subtract |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] hiAcc,
  input  logic [WIDTH-1:0] loAcc,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum     = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, operand} : '0);
    w_shifted = {hiAcc, loAcc[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, operand};
    nextHi    = w_sum[WIDTH:1];
    nextLo    = {w_sum[0], loAcc[WIDTH-1:1]};
    if (op == OP_DIV) begin
      // Borrow out of the (WIDTH+1)-bit subtract means restore.
      if (w_diff[WIDTH]) begin
        nextHi = w_shifted[WIDTH-1:0];
        nextLo = {loAcc[WIDTH-2:0], 1'b0};
      end else begin
        nextHi = w_diff[WIDTH-1:0];
        nextLo = {loAcc[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_sequencer : iterative mult/div with HI/LO and pipeline stall  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             opE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic [1:0]       mfhlD,
  input  logic             muldivD,
  input  logic             hlwriteW,
  input  logic             hlselW,
  input  logic [WIDTH-1:0] wdataW,
  input  logic [1:0]       mfhlW,
  output logic [WIDTH-1:0] hlrdataW,
  output logic             busy,
  output logic             stallD,
  output logic             done
);

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_count;
  logic               r_op;
  logic               r_negRes;
  logic               r_negRem;
  logic [WIDTH-1:0]   r_hiAcc;
  logic [WIDTH-1:0]   r_loAcc;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_negA, w_negB;
  logic [WIDTH-1:0]   w_absA, w_absB;
  logic [WIDTH-1:0]   w_stepHi, w_stepLo;
  logic [2*WIDTH-1:0] w_prod, w_prodFix;
  logic [WIDTH-1:0]   w_quot, w_rem;
  logic [WIDTH-1:0]   w_resHi, w_resLo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (r_op),
    .hiAcc   (r_hiAcc),
    .loAcc   (r_loAcc),
    .operand (r_operand),
    .nextHi  (w_stepHi),
    .nextLo  (w_stepLo)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (startE) w_nextState = RUN;
      RUN:     if (r_count == CNT_W'(1)) w_nextState = FIX;
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_negA    = signedE & srcaE[WIDTH-1];
    w_negB    = signedE & srcbE[WIDTH-1];
    w_absA    = w_negA ? -srcaE : srcaE;
    w_absB    = w_negB ? -srcbE : srcbE;
    w_prod    = {r_hiAcc, r_loAcc};
    w_prodFix = r_negRes ? -w_prod : w_prod;
    // A zero divisor never borrows, so the remainder ends up as |dividend|.
    w_quot    = (r_operand == '0) ? '1 : (r_negRes ? -r_loAcc : r_loAcc);
    w_rem     = r_negRem ? -r_hiAcc : r_hiAcc;
    w_resHi   = (r_op == OP_MUL) ? w_prodFix[2*WIDTH-1:WIDTH] : w_rem;
    w_resLo   = (r_op == OP_MUL) ? w_prodFix[WIDTH-1:0]       : w_quot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_op      <= OP_MUL;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_hiAcc   <= '0;
      r_loAcc   <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (hlwriteW) begin
        if (hlselW) r_hi <= wdataW;
        else        r_lo <= wdataW;
      end
      case (r_state)
        IDLE: begin
          if (startE) begin
            r_op      <= opE;
            r_negRes  <= w_negA ^ w_negB;
            r_negRem  <= w_negA;
            r_hiAcc   <= '0;
            r_loAcc   <= (opE == OP_MUL) ? w_absB : w_absA;
            r_operand <= (opE == OP_MUL) ? w_absA : w_absB;
            r_count   <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          r_hiAcc <= w_stepHi;
          r_loAcc <= w_stepLo;
          r_count <= r_count - CNT_W'(1);
        end
        FIX: begin
          // Placed after the mthi/mtlo write so the result takes priority.
          r_hi <= w_resHi;
          r_lo <= w_resLo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hlrdataW = '0;
    if (mfhlW == MFHL_HI)      hlrdataW = r_hi;
    else if (mfhlW == MFHL_LO) hlrdataW = r_lo;
  end

  assign busy   = (r_state == RUN) || (r_state == FIX);
  assign stallD = busy & ((mfhlD != MFHL_NONE) | muldivD);
  assign done   = (r_state == FIX);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_sequencer : directed self-checking bench for the mult/div  |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startE = 1'b0, opE = 1'b0, signedE = 1'b0;
  logic [31:0] srcaE = '0, srcbE = '0;
  logic [1:0]  mfhlD = 2'b00;
  logic        muldivD = 1'b0;
  logic        hlwriteW = 1'b0, hlselW = 1'b0;
  logic [31:0] wdataW = '0;
  logic [1:0]  mfhlW = 2'b00;
  logic [31:0] hlrdataW;
  logic        busy, stallD, done;

  int nTests = 0;
  int nFail  = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .signedE(signedE),
    .srcaE(srcaE), .srcbE(srcbE), .mfhlD(mfhlD), .muldivD(muldivD),
    .hlwriteW(hlwriteW), .hlselW(hlselW), .wdataW(wdataW), .mfhlW(mfhlW),
    .hlrdataW(hlrdataW), .busy(busy), .stallD(stallD), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic read_hl(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
    mfhlW = 2'b10; #1;
    check({tag, "_hi"}, hlrdataW, expHi);
    mfhlW = 2'b01; #1;
    check({tag, "_lo"}, hlrdataW, expLo);
    mfhlW = 2'b00;
  endtask

  // Returns at the negedge of the first busy cycle (start edge just passed).
  task automatic start_op(input logic op, input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    startE = 1'b1; opE = op; signedE = sg; srcaE = a; srcbE = b;
    @(negedge clk);
    startE = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int expBusy);
    int cnt = 0;
    int dn  = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      cnt++;
      if (done) dn++;
      @(negedge clk);
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_busycyc"}, cnt, expBusy);
    check({tag, "_donecnt"}, dn, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic op, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expHi, input logic [31:0] expLo);
    start_op(op, sg, a, b);
    wait_done(tag, 33);
    read_hl(tag, expHi, expLo);
  endtask

  initial begin
    int dn;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_stall", {31'b0, stallD}, 32'd0);
    read_hl("rst", 32'h0, 32'h0);

    mfhlD = 2'b10; muldivD = 1'b1; #1;
    check("idle_nostall", {31'b0, stallD}, 32'd0);
    mfhlD = 2'b00; muldivD = 1'b0;

    // mthi in IDLE; the same-cycle read still shows the old HI value
    @(negedge clk);
    hlwriteW = 1'b1; hlselW = 1'b1; wdataW = 32'h1234; mfhlW = 2'b10; #1;
    check("nobypass", hlrdataW, 32'h0);
    @(negedge clk);
    hlwriteW = 1'b0; #1;
    check("mthi_read", hlrdataW, 32'h1234);
    mfhlW = 2'b00; #1;
    check("mfhl_none", hlrdataW, 32'h0);

    run_op("multu_ff_2", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);
    run_op("div_m7_2",   1'b1, 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("mult_m3_5",  1'b0, 1'b1, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("divu_100_0", 1'b1, 1'b0, 32'd100, 32'h0, 32'd100, 32'hFFFFFFFF);
    run_op("div_ovf",    1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu_1000_7",1'b1, 1'b0, 32'd1000, 32'd7, 32'd6, 32'd142);
    run_op("multu_big",  1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h1, 32'h0);

    // mtlo and startE in the same IDLE cycle both take effect
    @(negedge clk);
    startE = 1'b1; opE = 1'b0; signedE = 1'b0; srcaE = 32'd6; srcbE = 32'd7;
    hlwriteW = 1'b1; hlselW = 1'b0; wdataW = 32'hCAFE;
    @(negedge clk);
    startE = 1'b0; hlwriteW = 1'b0;
    mfhlW = 2'b01; #1;
    check("mtlo_with_start", hlrdataW, 32'hCAFE);
    mfhlW = 2'b00;
    mfhlD = 2'b10; #1;
    check("stall_mfhi", {31'b0, stallD}, 32'd1);
    mfhlD = 2'b00; muldivD = 1'b1; #1;
    check("stall_muldiv", {31'b0, stallD}, 32'd1);
    muldivD = 1'b0; #1;
    check("nostall_busy", {31'b0, stallD}, 32'd0);
    // illegal start mid-RUN plus an mthi that the result must overwrite
    startE = 1'b1; opE = 1'b1; signedE = 1'b1; srcaE = 32'd99; srcbE = 32'd3;
    hlwriteW = 1'b1; hlselW = 1'b1; wdataW = 32'hDEAD;
    @(negedge clk);
    startE = 1'b0; hlwriteW = 1'b0;
    mfhlW = 2'b10; #1;
    check("mthi_in_run", hlrdataW, 32'hDEAD);
    mfhlW = 2'b00;
    wait_done("ignore_start", 32);
    read_hl("ignore_start", 32'h0, 32'd42);

    // reset in the middle of RUN
    start_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    read_hl("abort", 32'h0, 32'h0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_nodone", dn, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
